ddr_io: RTL and testbench

DDR_IO -- requirements
Module: ddr_io

---
 rtl/ddr_io_pkg.sv | 16 +
 rtl/ddr_io_mem.sv | 22 ++
 rtl/ddr_io.sv | 182 ++++++++++++++++++
 tb/tb_ddr_io.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ddr_io_pkg.sv
// ddr_io_pkg: shared widths, AXI encodings and FSM state types for the ddr_io model.
package ddr_io_pkg;
   localparam int ID_W   = 4;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int LEN_W  = 8;
   localparam int STRB_W = DATA_W / 8;
   localparam logic [1:0] OKAY = 2'b00;
   typedef enum logic [1:0] {FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10} burst_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;
   // WRAP is treated as INCR: the model never wraps inside a burst.
   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a, input burst_t b);
      return (b == FIXED) ? a : a + ADDR_W'(4);
   endfunction
endpackage

// File: rtl/ddr_io_mem.sv
// ddr_io_mem: single-clock word RAM with byte-enable write and registered read.
module ddr_io_mem import ddr_io_pkg::*; #(
   parameter int WORDS = 4096,
   parameter int AW    = $clog2(WORDS)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [STRB_W-1:0] be,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [WORDS];
   // Read-first: a same-cycle write to raddr is not visible until the next read.
   always_ff @(posedge clk) begin
      for (int i = 0; i < STRB_W; i++)
         if (we && be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/ddr_io.sv
// ddr_io: behavioural DDR3 controller stand-in -- AXI slave over an on-chip RAM,
// with a fixed calibration delay and idle DDR3 pins.
module ddr_io import ddr_io_pkg::*; #(
   parameter int MEM_WORDS    = 4096,
   parameter int CALIB_CYCLES = 1000
) (
   input  logic              sys_clk,
   input  logic              sys_rstn,
   output logic              ui_clk,
   output logic              ui_rstn,
   output logic              init_calib_complete,
   input  logic [ID_W-1:0]   m_axi_awid,
   input  logic [ADDR_W-1:0] m_axi_awaddr,
   input  logic [LEN_W-1:0]  m_axi_awlen,
   input  logic [2:0]        m_axi_awsize,
   input  logic [1:0]        m_axi_awburst,
   input  logic              m_axi_awlock,
   input  logic [3:0]        m_axi_awcache,
   input  logic [2:0]        m_axi_awprot,
   input  logic              m_axi_awvalid,
   output logic              m_axi_awready,
   input  logic [DATA_W-1:0] m_axi_wdata,
   input  logic [STRB_W-1:0] m_axi_wstrb,
   input  logic              m_axi_wlast,
   input  logic              m_axi_wvalid,
   output logic              m_axi_wready,
   input  logic              m_axi_bready,
   output logic [ID_W-1:0]   m_axi_bid,
   output logic [1:0]        m_axi_bresp,
   output logic              m_axi_bvalid,
   input  logic [ID_W-1:0]   m_axi_arid,
   input  logic [ADDR_W-1:0] m_axi_araddr,
   input  logic [LEN_W-1:0]  m_axi_arlen,
   input  logic [2:0]        m_axi_arsize,
   input  logic [1:0]        m_axi_arburst,
   input  logic              m_axi_arlock,
   input  logic [3:0]        m_axi_arcache,
   input  logic [2:0]        m_axi_arprot,
   input  logic              m_axi_arvalid,
   output logic              m_axi_arready,
   input  logic              m_axi_rready,
   output logic [ID_W-1:0]   m_axi_rid,
   output logic [DATA_W-1:0] m_axi_rdata,
   output logic [1:0]        m_axi_rresp,
   output logic              m_axi_rlast,
   output logic              m_axi_rvalid,
   output logic              ddr3_reset_n,
   output logic              ddr3_ras_n,
   output logic              ddr3_cas_n,
   output logic              ddr3_we_n,
   output logic [13:0]       ddr3_addr,
   output logic [2:0]        ddr3_ba,
   output logic [0:0]        ddr3_ck_p,
   output logic [0:0]        ddr3_ck_n,
   output logic [0:0]        ddr3_cke,
   output logic [0:0]        ddr3_cs_n,
   output logic [1:0]        ddr3_dm,
   output logic [0:0]        ddr3_odt,
   inout  wire  [15:0]       ddr3_dq,
   inout  wire  [1:0]        ddr3_dqs_p,
   inout  wire  [1:0]        ddr3_dqs_n
);
   localparam int IW = $clog2(MEM_WORDS);
   localparam int CW = $clog2(CALIB_CYCLES + 1);
   function automatic logic [IW-1:0] idx(input logic [ADDR_W-3:0] w);
      return IW'(w % (ADDR_W-2)'(MEM_WORDS));
   endfunction
   logic [1:0] rsync;
   logic [CW-1:0] ccnt;
   w_state_t ws, ws_nx;
   r_state_t rs, rs_nx;
   logic [ADDR_W-1:0] waddr, raddr, raddr_nx;
   logic [LEN_W-1:0] wcnt, rcnt;
   burst_t wburst, rburst;
   logic [ID_W-1:0] wid, rid;
   logic aw_hs, w_hs, ar_hs, r_hs, rlast_i, re;
   logic [IW-1:0] mem_raddr;
   logic [DATA_W-1:0] mem_q;
   logic unused;
   assign ui_clk = sys_clk;
   assign ui_rstn = rsync[1];
   // Reset asserts immediately with sys_rstn and is released through two flops.
   always_ff @(posedge sys_clk or negedge sys_rstn)
      if (!sys_rstn) rsync <= 2'b00;
      else rsync <= {rsync[0], 1'b1};
   always_ff @(posedge sys_clk or negedge ui_rstn)
      if (!ui_rstn) begin
         ccnt <= '0;
         init_calib_complete <= 1'b0;
      end else if (!init_calib_complete) begin
         if (ccnt == CW'(CALIB_CYCLES - 1)) init_calib_complete <= 1'b1;
         else ccnt <= ccnt + 1'b1;
      end
   always_comb begin
      aw_hs = (ws == W_IDLE) && init_calib_complete && m_axi_awvalid;
      w_hs  = (ws == W_DATA) && m_axi_wvalid;
      ws_nx = aw_hs ? W_DATA :
              (w_hs && wcnt == '0) ? W_RESP :
              (ws == W_RESP && m_axi_bready) ? W_IDLE : ws;
      m_axi_awready = (ws == W_IDLE) && init_calib_complete;
      m_axi_wready  = (ws == W_DATA);
      m_axi_bvalid  = (ws == W_RESP);
      m_axi_bid     = wid;
      m_axi_bresp   = OKAY;
   end
   always_ff @(posedge sys_clk or negedge ui_rstn)
      if (!ui_rstn) begin
         ws <= W_IDLE;
         wid <= '0;
         waddr <= '0;
         wcnt <= '0;
         wburst <= FIXED;
      end else begin
         ws <= ws_nx;
         if (aw_hs) begin
            wid <= m_axi_awid;
            waddr <= m_axi_awaddr;
            wcnt <= m_axi_awlen;
            wburst <= burst_t'(m_axi_awburst);
         end else if (w_hs) begin
            waddr <= next_addr(waddr, wburst);
            wcnt <= wcnt - 1'b1;
         end
      end
   // The RAM read is launched on the handshake so rdata is ready with rvalid and held on stall.
   assign raddr_nx = next_addr(raddr, rburst);
   always_comb begin
      ar_hs = (rs == R_IDLE) && init_calib_complete && m_axi_arvalid;
      r_hs  = (rs == R_DATA) && m_axi_rready;
      rlast_i = (rcnt == '0);
      rs_nx = ar_hs ? R_DATA : (r_hs && rlast_i) ? R_IDLE : rs;
      re = ar_hs || (r_hs && !rlast_i);
      mem_raddr = (rs == R_IDLE) ? idx(m_axi_araddr[ADDR_W-1:2]) : idx(raddr_nx[ADDR_W-1:2]);
      m_axi_arready = (rs == R_IDLE) && init_calib_complete;
      m_axi_rvalid  = (rs == R_DATA);
      m_axi_rlast   = m_axi_rvalid && rlast_i;
      m_axi_rdata   = m_axi_rvalid ? mem_q : '0;
      m_axi_rid     = rid;
      m_axi_rresp   = OKAY;
   end
   always_ff @(posedge sys_clk or negedge ui_rstn)
      if (!ui_rstn) begin
         rs <= R_IDLE;
         rid <= '0;
         raddr <= '0;
         rcnt <= '0;
         rburst <= FIXED;
      end else begin
         rs <= rs_nx;
         if (ar_hs) begin
            rid <= m_axi_arid;
            raddr <= m_axi_araddr;
            rcnt <= m_axi_arlen;
            rburst <= burst_t'(m_axi_arburst);
         end else if (r_hs && !rlast_i) begin
            raddr <= raddr_nx;
            rcnt <= rcnt - 1'b1;
         end
      end
   ddr_io_mem #(.WORDS(MEM_WORDS), .AW(IW)) u_mem (
      .clk(sys_clk), .we(w_hs), .be(m_axi_wstrb), .waddr(idx(waddr[ADDR_W-1:2])),
      .wdata(m_axi_wdata), .re(re), .raddr(mem_raddr), .rdata(mem_q)
   );
   assign ddr3_reset_n = ui_rstn;
   assign ddr3_cke   = init_calib_complete;
   assign ddr3_cs_n  = 1'b1;
   assign ddr3_ras_n = 1'b1;
   assign ddr3_cas_n = 1'b1;
   assign ddr3_we_n  = 1'b1;
   assign ddr3_addr  = '0;
   assign ddr3_ba    = '0;
   assign ddr3_dm    = '0;
   assign ddr3_odt   = '0;
   assign ddr3_ck_p  = sys_clk;
   assign ddr3_ck_n  = ~sys_clk;
   assign ddr3_dq    = 'z;
   assign ddr3_dqs_p = 'z;
   assign ddr3_dqs_n = 'z;
   assign unused = ^{m_axi_awsize, m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_wlast,
                     m_axi_arsize, m_axi_arlock, m_axi_arcache, m_axi_arprot,
                     ddr3_dq, ddr3_dqs_p, ddr3_dqs_n};
endmodule

// File: tb/tb_ddr_io.sv
// tb_ddr_io: table-driven AXI write/read vectors plus stall, calibration and reset sequences.
module tb_ddr_io;
   import ddr_io_pkg::*;
   localparam int MW = 4096;
   localparam int CC = 20;
   logic clk = 1'b0, rstn = 1'b0;
   always #5 clk = ~clk;
   logic ui_clk, ui_rstn, calib;
   logic [3:0] awid, arid, bid, rid;
   logic [31:0] awaddr, araddr, wdata, rdata;
   logic [7:0] awlen, arlen;
   logic [1:0] awburst, arburst, bresp, rresp;
   logic [3:0] wstrb;
   logic awvalid, awready, wlast, wvalid, wready, bready, bvalid;
   logic arvalid, arready, rready, rlast, rvalid;
   logic d_reset_n, d_ras_n, d_cas_n, d_we_n;
   logic [13:0] d_addr;
   logic [2:0] d_ba;
   logic [0:0] d_ck_p, d_ck_n, d_cke, d_cs_n, d_odt;
   logic [1:0] d_dm;
   wire [15:0] d_dq;
   wire [1:0] d_dqs_p, d_dqs_n;
   int n_vec = 0, n_fail = 0;

   ddr_io #(.MEM_WORDS(MW), .CALIB_CYCLES(CC)) dut (
      .sys_clk(clk), .sys_rstn(rstn), .ui_clk(ui_clk), .ui_rstn(ui_rstn), .init_calib_complete(calib),
      .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(3'd2),
      .m_axi_awburst(awburst), .m_axi_awlock(1'b0), .m_axi_awcache(4'd0), .m_axi_awprot(3'd0),
      .m_axi_awvalid(awvalid), .m_axi_awready(awready),
      .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
      .m_axi_bready(bready), .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
      .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(3'd2),
      .m_axi_arburst(arburst), .m_axi_arlock(1'b0), .m_axi_arcache(4'd0), .m_axi_arprot(3'd0),
      .m_axi_arvalid(arvalid), .m_axi_arready(arready),
      .m_axi_rready(rready), .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
      .m_axi_rlast(rlast), .m_axi_rvalid(rvalid),
      .ddr3_reset_n(d_reset_n), .ddr3_ras_n(d_ras_n), .ddr3_cas_n(d_cas_n), .ddr3_we_n(d_we_n),
      .ddr3_addr(d_addr), .ddr3_ba(d_ba), .ddr3_ck_p(d_ck_p), .ddr3_ck_n(d_ck_n), .ddr3_cke(d_cke),
      .ddr3_cs_n(d_cs_n), .ddr3_dm(d_dm), .ddr3_odt(d_odt),
      .ddr3_dq(d_dq), .ddr3_dqs_p(d_dqs_p), .ddr3_dqs_n(d_dqs_n)
   );

   typedef struct {
      logic wr;
      logic [3:0] id;
      logic [31:0] addr;
      logic [7:0] len;
      logic [1:0] burst;
      logic [3:0] strb;
      logic chk;
      logic [3:0][31:0] d;
   } vec_t;
   vec_t vecs[13];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
      end
   endtask

   task automatic calib_seq(input string nm);
      int n;
      logic bad;
      bad = 1'b0;
      for (n = 0; n < 100 && !ui_rstn; n++) @(negedge clk);
      check({nm, " ui_rstn_release"}, {31'd0, ui_rstn}, 32'd1);
      n = 0;
      while (!calib && n < CC + 50) begin
         if (awready || wready || arready || bvalid || rvalid) bad = 1'b1;
         @(negedge clk);
         n++;
      end
      check({nm, " calib_delay"}, n, CC);
      check({nm, " readies_low_before_calib"}, {31'd0, bad}, 32'd0);
      check({nm, " ready_after_calib"}, {28'd0, awready, arready, d_cke, calib}, 32'hF);
   endtask

   task automatic do_write(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                           input logic [1:0] bt, input logic [3:0] st, input logic [3:0][31:0] d, input string nm);
      int t;
      awid = id; awaddr = a; awlen = len; awburst = bt; awvalid = 1'b1;
      for (t = 0; t < 200 && !awready; t++) @(negedge clk);
      if (!awready) begin
         check({nm, " aw_timeout"}, 32'd0, 32'd1);
         awvalid = 1'b0;
         return;
      end
      @(negedge clk);
      awvalid = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         wdata = d[b]; wstrb = st; wlast = (b == int'(len)); wvalid = 1'b1;
         for (t = 0; t < 200 && !wready; t++) @(negedge clk);
         if (!wready) begin
            check({nm, " w_timeout"}, 32'd0, 32'd1);
            wvalid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
      for (t = 0; t < 200 && !bvalid; t++) @(negedge clk);
      check({nm, " bvalid"}, {31'd0, bvalid}, 32'd1);
      check({nm, " bid/bresp"}, {26'd0, bid, bresp}, {26'd0, id, 2'b00});
      @(negedge clk);
      bready = 1'b0;
      check({nm, " b_done"}, {30'd0, bvalid, awready}, 32'd1);
   endtask

   task automatic do_read(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                          input logic [1:0] bt, input logic chk, input logic [3:0][31:0] e, input string nm);
      int t;
      arid = id; araddr = a; arlen = len; arburst = bt; arvalid = 1'b1; rready = 1'b0;
      for (t = 0; t < 200 && !arready; t++) @(negedge clk);
      if (!arready) begin
         check({nm, " ar_timeout"}, 32'd0, 32'd1);
         arvalid = 1'b0;
         return;
      end
      @(negedge clk);
      arvalid = 1'b0; rready = 1'b1;
      for (int b = 0; b <= int'(len); b++) begin
         for (t = 0; t < 200 && !rvalid; t++) @(negedge clk);
         if (chk) check($sformatf("%s rdata[%0d]", nm, b), rdata, e[b]);
         check($sformatf("%s rvalid/rlast/rid/rresp[%0d]", nm, b), {24'd0, rvalid, rlast, id, rresp},
               {24'd0, 1'b1, (b == int'(len)), id, 2'b00});
         @(negedge clk);
      end
      rready = 1'b0;
      check({nm, " back_to_idle"}, {30'd0, rvalid, arready}, 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0]  = '{1'b0, 4'h2, 32'h0000_0000, 8'd0, INCR,  4'hF, 1'b0, {32'd0, 32'd0, 32'd0, 32'd0}};
      vecs[1]  = '{1'b1, 4'h3, 32'h0000_0000, 8'd0, INCR,  4'hF, 1'b0, {32'd0, 32'd0, 32'd0, 32'h4D2}};
      vecs[2]  = '{1'b0, 4'h5, 32'h0000_0000, 8'd0, INCR,  4'hF, 1'b1, {32'd0, 32'd0, 32'd0, 32'h4D2}};
      vecs[3]  = '{1'b1, 4'h1, 32'h0000_0100, 8'd3, INCR,  4'hF, 1'b0, {32'd4, 32'd3, 32'd2, 32'd1}};
      vecs[4]  = '{1'b0, 4'h6, 32'h0000_0100, 8'd3, INCR,  4'hF, 1'b1, {32'd4, 32'd3, 32'd2, 32'd1}};
      vecs[5]  = '{1'b1, 4'h9, 32'h0000_0014, 8'd0, INCR,  4'hF, 1'b0, {32'd0, 32'd0, 32'd0, 32'hAABBCCDD}};
      vecs[6]  = '{1'b1, 4'hA, 32'h0000_0014, 8'd0, INCR,  4'b0010, 1'b0, {32'd0, 32'd0, 32'd0, 32'h0000EE00}};
      vecs[7]  = '{1'b0, 4'hB, 32'h0000_0014, 8'd0, INCR,  4'hF, 1'b1, {32'd0, 32'd0, 32'd0, 32'hAABBEEDD}};
      vecs[8]  = '{1'b1, 4'hC, MW * 4,        8'd0, INCR,  4'hF, 1'b0, {32'd0, 32'd0, 32'd0, 32'h12345678}};
      vecs[9]  = '{1'b0, 4'hD, 32'h0000_0000, 8'd0, INCR,  4'hF, 1'b1, {32'd0, 32'd0, 32'd0, 32'h12345678}};
      vecs[10] = '{1'b1, 4'hE, 32'h0000_0200, 8'd2, FIXED, 4'hF, 1'b0, {32'd0, 32'd9, 32'd8, 32'd7}};
      vecs[11] = '{1'b0, 4'hF, 32'h0000_0200, 8'd1, FIXED, 4'hF, 1'b1, {32'd0, 32'd0, 32'd9, 32'd9}};
      vecs[12] = '{1'b0, 4'h4, 32'h0000_0100, 8'd1, WRAP,  4'hF, 1'b1, {32'd0, 32'd0, 32'd2, 32'd1}};
      awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
      wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
      arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
      repeat (3) @(negedge clk);
      check("reset axi outputs", {awready, wready, bvalid, arready, rvalid, rlast, bid, rid, bresp, rresp},
            32'd0);
      check("reset rdata", rdata, 32'd0);
      check("reset ui/calib/ddr", {20'd0, ui_rstn, calib, d_reset_n, d_cke, d_cs_n, d_ras_n, d_cas_n, d_we_n,
            d_odt, d_dm, |d_addr}, 32'h000000F0);
      check("ddr clocks", {30'd0, d_ck_p, d_ck_n}, {30'd0, clk, ~clk});
      rstn = 1'b1;
      calib_seq("boot");
      check("ddr pins after calib", {24'd0, d_reset_n, d_cke, d_cs_n, d_ras_n, d_cas_n, d_we_n, |d_ba, |d_dm},
            32'h000000FC);

      for (int i = 0; i < 13; i++)
         if (vecs[i].wr)
            do_write(vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].burst, vecs[i].strb, vecs[i].d,
                     $sformatf("v%0d_wr", i));
         else
            do_read(vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].burst, vecs[i].chk, vecs[i].d,
                    $sformatf("v%0d_rd", i));

      // rready held low: the first beat must sit unchanged for three cycles
      arid = 4'h7; araddr = 32'h100; arlen = 8'd3; arburst = INCR; arvalid = 1'b1; rready = 1'b0;
      for (int t = 0; t < 200 && !arready; t++) @(negedge clk);
      @(negedge clk);
      arvalid = 1'b0;
      for (int s = 0; s < 3; s++) begin
         check($sformatf("stall rdata[%0d]", s), rdata, 32'd1);
         check($sformatf("stall ctl[%0d]", s), {26'd0, rvalid, rlast, rid}, {26'd0, 1'b1, 1'b0, 4'h7});
         @(negedge clk);
      end
      rready = 1'b1;
      for (int b = 0; b < 4; b++) begin
         check($sformatf("stall beat rdata[%0d]", b), rdata, b + 1);
         check($sformatf("stall beat rlast[%0d]", b), {30'd0, rvalid, rlast}, {30'd0, 1'b1, (b == 3)});
         @(negedge clk);
      end
      rready = 1'b0;
      check("stall idle", {30'd0, rvalid, arready}, 32'd1);

      // reset asserted while a read burst is in flight
      arid = 4'h2; araddr = 32'h100; arlen = 8'd3; arburst = INCR; arvalid = 1'b1;
      for (int t = 0; t < 200 && !arready; t++) @(negedge clk);
      @(negedge clk);
      arvalid = 1'b0;
      check("midburst rvalid before reset", {31'd0, rvalid}, 32'd1);
      #1 rstn = 1'b0;
      #1;
      check("midburst reset immediate", {28'd0, rvalid, calib, ui_rstn, arready}, 32'd0);
      check("midburst reset rdata", rdata, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      calib_seq("rereset");
      do_read(4'h8, 32'h100, 8'd3, INCR, 1'b1, {32'd4, 32'd3, 32'd2, 32'd1}, "post_reset_burst");
      do_read(4'h9, 32'h14, 8'd0, INCR, 1'b1, {32'd0, 32'd0, 32'd0, 32'hAABBEEDD}, "post_reset_word5");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
